// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 16-bit words and streams them into instruction RAM.
// Optional HALT append on finish is enabled by defining ENCODER_HALT_APPEND_EN.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        fmt_i,
  input  logic [2:0]        opcode_i,
  input  logic [1:0]        op_i,
  input  logic [2:0]        rn_i,
  input  logic [2:0]        rd_i,
  input  logic [2:0]        rm_i,
  input  logic [1:0]        shift_i,
  input  logic [15:0]       imm_i,
  input  logic              finish_i,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  output logic [ADDR_W:0]   wr_count_o,
  output logic              full_o,
  output logic              err_range_o,
  output logic              done_o
);

  localparam logic [1:0]        FMT_REG  = 2'd0;
  localparam logic [1:0]        FMT_IMM8 = 2'd1;
  localparam logic [1:0]        FMT_IMM5 = 2'd2;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [15:0]       HALT_W   = 16'hE000;

  typedef enum logic [2:0] {IDLE, WRITE, HALT_WR, FULL, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [15:0]         word_c;
  logic                legal_c;
  logic                last_c;

  // Pack fields and range-check the immediate for the selected format.
  always_comb begin
    word_c  = {opcode_i, op_i, 11'b0};
    legal_c = 1'b1;
    case (fmt_i)
      FMT_REG: word_c = {opcode_i, op_i, rn_i, rd_i, shift_i, rm_i};
      FMT_IMM8: begin
        word_c  = {opcode_i, op_i, rn_i, imm_i[7:0]};
        legal_c = (&imm_i[15:7]) | ~(|imm_i[15:7]);
      end
      FMT_IMM5: begin
        word_c  = {opcode_i, op_i, rn_i, rd_i, imm_i[4:0]};
        legal_c = (&imm_i[15:4]) | ~(|imm_i[15:4]);
      end
      default: ;
    endcase
  end

  // The write in progress is the one that fills memory; the pointer then stays put.
  assign last_c = (cnt_q + CNT_ONE) == DEPTH_C;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (legal_c) begin
            addr_d  = ptr_q;
            wdata_d = word_c;
            state_d = WRITE;
          end else begin
            err_d = 1'b1;
          end
        end else if (finish_i) begin
`ifdef ENCODER_HALT_APPEND_EN
          addr_d  = ptr_q;
          wdata_d = HALT_W;
          state_d = HALT_WR;
`else
          state_d = DONE;
`endif
        end
      end
      WRITE: begin
        cnt_d   = cnt_q + CNT_ONE;
        ptr_d   = last_c ? ptr_q : ptr_q + PTR_ONE;
        state_d = last_c ? FULL : IDLE;
      end
      HALT_WR: begin
        cnt_d   = cnt_q + CNT_ONE;
        ptr_d   = last_c ? ptr_q : ptr_q + PTR_ONE;
        state_d = DONE;
      end
      FULL: if (finish_i) state_d = DONE;
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign mem_write_o = (state_q == WRITE) || (state_q == HALT_WR);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign wr_count_o  = cnt_q;
  assign full_o      = (cnt_q == DEPTH_C);
  assign err_range_o = err_q;
  assign done_o      = (state_q == DONE);

endmodule
